// File: rtl/crc32_pkg.sv
// crc32_pkg: CRC-32 constants, bit-serial step functions and result flag type for the FCS checker.
package crc32_pkg;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  typedef enum logic {IDLE, RUN} state_t;
  typedef struct packed {
    logic ok;
    logic crc_err;
    logic runt;
    logic abort;
  } res_flags_t;
  // Bit 0 of each byte is the first bit on the wire; the register shifts MSB-out.
  function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] d8);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) c = {c[30:0], 1'b0} ^ ((c[31] ^ d8[i]) ? CRC32_POLY : 32'h0);
    return c;
  endfunction
  function automatic logic [31:0] crc32_step16(input logic [31:0] crc, input logic [15:0] d16);
    return crc32_step8(crc32_step8(crc, d16[7:0]), d16[15:8]);
  endfunction
endpackage

// File: rtl/crc32_fcs_checker_if.sv
// crc32_fcs_checker_if: framed 16-bit receive stream in, per-frame result out.
interface crc32_fcs_checker_if;
  logic        in_valid;
  logic        in_sof;
  logic        in_eof;
  logic        in_odd;
  logic [15:0] in_data;
  logic        res_valid;
  logic        res_ok;
  logic        res_crc_err;
  logic        res_runt;
  logic        res_abort;
  logic [15:0] res_len;
  modport master (output in_valid, in_sof, in_eof, in_odd, in_data,
                  input  res_valid, res_ok, res_crc_err, res_runt, res_abort, res_len);
  modport slave  (input  in_valid, in_sof, in_eof, in_odd, in_data,
                  output res_valid, res_ok, res_crc_err, res_runt, res_abort, res_len);
endinterface

// File: rtl/crc32_sat_counter.sv
// crc32_sat_counter: W-bit incrementer that sticks at all-ones.
module crc32_sat_counter #(
  parameter int W = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/crc32_fcs_checker.sv
// crc32_fcs_checker: accumulates CRC-32 over frame+FCS, checks the residue and length,
// reports a registered per-frame result and keeps saturating good/bad/runt counters.
module crc32_fcs_checker
  import crc32_pkg::*;
#(
  parameter logic [31:0] RESIDUE   = CRC32_RESIDUE,
  parameter int          MIN_BYTES = 64,
  parameter int          CNT_W     = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  crc32_fcs_checker_if.slave bus,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_runt
);
  localparam logic [15:0] MIN_LEN = 16'(MIN_BYTES);
  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_src, crc_nx;
  logic [15:0] len_q, len_d, len_src, len_nx, rlen_q, rlen_d;
  logic [16:0] len_sum;
  res_flags_t  flags_q, flags_d;
  logic        valid_q, valid_d;
  logic        start, beat, last_odd, abort, fin;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      crc_q   <= CRC32_INIT;
      len_q   <= '0;
      valid_q <= 1'b0;
      flags_q <= '0;
      rlen_q  <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
      rlen_q  <= rlen_d;
    end
  // A new in_sof always restarts accumulation, whether or not a frame was open.
  always_comb begin
    start    = bus.in_valid & bus.in_sof;
    beat     = bus.in_valid & (bus.in_sof | (state_q == RUN));
    last_odd = bus.in_eof & bus.in_odd;
    abort    = start & (state_q == RUN);
    fin      = beat & bus.in_eof & ~abort;
    crc_src  = start ? CRC32_INIT : crc_q;
    len_src  = start ? 16'h0 : len_q;
    crc_nx   = last_odd ? crc32_step8(crc_src, bus.in_data[7:0]) : crc32_step16(crc_src, bus.in_data);
    len_sum  = {1'b0, len_src} + (last_odd ? 17'd1 : 17'd2);
    len_nx   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    state_d  = beat ? (bus.in_eof ? IDLE : RUN) : state_q;
    crc_d    = beat ? (bus.in_eof ? CRC32_INIT : crc_nx) : crc_q;
    len_d    = beat ? (bus.in_eof ? 16'h0 : len_nx) : len_q;
    valid_d  = abort | fin;
    flags_d  = flags_q;
    rlen_d   = rlen_q;
    if (abort) begin
      flags_d = '{ok: 1'b0, crc_err: 1'b0, runt: len_q < MIN_LEN, abort: 1'b1};
      rlen_d  = len_q;
    end else if (fin) begin
      flags_d = '{ok: (crc_nx == RESIDUE) && (len_nx >= MIN_LEN), crc_err: crc_nx != RESIDUE,
                  runt: len_nx < MIN_LEN, abort: 1'b0};
      rlen_d  = len_nx;
    end
  end
  assign bus.res_valid   = valid_q;
  assign bus.res_ok      = flags_q.ok;
  assign bus.res_crc_err = flags_q.crc_err;
  assign bus.res_runt    = flags_q.runt;
  assign bus.res_abort   = flags_q.abort;
  assign bus.res_len     = rlen_q;
  // Counters step on the same edge the result registers load.
  crc32_sat_counter #(.W(CNT_W)) u_good (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .inc_i(valid_d & flags_d.ok), .cnt_o(cnt_good));
  crc32_sat_counter #(.W(CNT_W)) u_bad (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .inc_i(valid_d & (flags_d.crc_err | flags_d.abort)), .cnt_o(cnt_bad));
  crc32_sat_counter #(.W(CNT_W)) u_runt (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .inc_i(valid_d & flags_d.runt), .cnt_o(cnt_runt));
endmodule

// File: tb/tb_crc32_fcs_checker.sv
// tb_crc32_fcs_checker: directed frames checked against a reflected (Ethernet-style) CRC-32
// byte model and a result scoreboard, plus literal expectations per scenario.
module tb_crc32_fcs_checker;
  localparam int CW  = 4;
  localparam int CMX = (1 << CW) - 1;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int due;
    bit ok, err, runt, abort;
    int len;
  } exp_t;
  logic sys_clk, sys_rst_n;
  logic [CW-1:0] cnt_good, cnt_bad, cnt_runt;
  crc32_fcs_checker_if bus();
  crc32_fcs_checker #(.MIN_BYTES(64), .CNT_W(CW)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .bus(bus), .cnt_good(cnt_good), .cnt_bad(cnt_bad), .cnt_runt(cnt_runt));
  int checks = 0, failures = 0, cyc = 0;
  exp_t expq[$];
  int mg = 0, mb = 0, mr = 0;
  bit open = 0;
  int open_len = 0;
  initial sys_clk = 0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Standard LSB-first reflected CRC-32 register, no final inversion.
  function automatic logic [31:0] ref_crc(input bq_t f);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (f[k]) begin
      c ^= {24'h0, f[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
  function automatic bq_t build(input int np);
    bq_t q;
    logic [31:0] fcs;
    for (int k = 0; k < np; k++) q.push_back(8'($urandom));
    fcs = ~ref_crc(q);
    for (int k = 0; k < 4; k++) q.push_back(fcs[8*k +: 8]);
    return q;
  endfunction
  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      expq.delete();
      mg = 0; mb = 0; mr = 0;
      chk("rst_res_valid", {31'h0, bus.res_valid}, 0);
    end else if (expq.size() != 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      chk("res_valid", {31'h0, bus.res_valid}, 1);
      chk("res_ok", {31'h0, bus.res_ok}, {31'h0, e.ok});
      chk("res_crc_err", {31'h0, bus.res_crc_err}, {31'h0, e.err});
      chk("res_runt", {31'h0, bus.res_runt}, {31'h0, e.runt});
      chk("res_abort", {31'h0, bus.res_abort}, {31'h0, e.abort});
      chk("res_len", {16'h0, bus.res_len}, e.len);
      if (e.ok) mg = (mg == CMX) ? CMX : mg + 1;
      if (e.err || e.abort) mb = (mb == CMX) ? CMX : mb + 1;
      if (e.runt) mr = (mr == CMX) ? CMX : mr + 1;
    end else chk("res_valid_idle", {31'h0, bus.res_valid}, 0);
    chk("cnt_good", {28'h0, cnt_good}, mg);
    chk("cnt_bad", {28'h0, cnt_bad}, mb);
    chk("cnt_runt", {28'h0, cnt_runt}, mr);
  end
  task automatic idle_cycle();
    bus.in_valid = 0;
    bus.in_sof = 1'($urandom);
    bus.in_eof = 1'($urandom);
    bus.in_odd = 1'($urandom);
    bus.in_data = 16'($urandom);
    @(posedge sys_clk); #1;
  endtask
  // cut >= 0 sends only that many beats and leaves the frame open.
  task automatic send(input bq_t f, input int cut, input bit gaps, input bit garbage);
    int n = f.size(), nb = (f.size() + 1) / 2;
    int lim = (cut < 0) ? nb : cut;
    int len;
    bit last, crc_ok;
    logic [7:0] hi;
    for (int i = 0; i < lim; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
      last = (cut < 0) && (i == nb - 1);
      hi = (2 * i + 1 < n) ? f[2 * i + 1] : (garbage ? 8'($urandom) : 8'h00);
      bus.in_valid = 1;
      bus.in_sof = (i == 0);
      bus.in_eof = last;
      bus.in_odd = last ? (n % 2 == 1) : 1'($urandom);
      bus.in_data = {hi, f[2 * i]};
      if (i == 0) begin
        if (open) expq.push_back('{due: cyc + 1, ok: 0, err: 0, runt: open_len < 64, abort: 1, len: open_len});
        open = 1;
        open_len = 0;
      end
      open_len += (2 * i + 1 < n) ? 2 : 1;
      if (open_len > 65535) open_len = 65535;
      if (last) begin
        len = (n > 65535) ? 65535 : n;
        crc_ok = ref_crc(f) == 32'hDEBB20E3;
        expq.push_back('{due: cyc + 1, ok: crc_ok && len >= 64, err: !crc_ok, runt: len < 64, abort: 0, len: len});
        open = 0;
      end
      @(posedge sys_clk); #1;
    end
    bus.in_valid = 0;
  endtask
  initial begin
    bq_t f64, fbad, f65, f20, fone, fbig, pin;
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
  initial begin
    bq_t f64, fbad, f65, f20, fone, fbig, pin;
    sys_rst_n = 0;
    bus.in_valid = 0; bus.in_sof = 0; bus.in_eof = 0; bus.in_odd = 0; bus.in_data = 0;
    pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_check_123456789", ~ref_crc(pin), 32'hCBF43926);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_res_len", {16'h0, bus.res_len}, 0);
    chk("reset_cnt_good", {28'h0, cnt_good}, 0);
    sys_rst_n = 1;
    repeat (2) idle_cycle();
    f64 = build(60);
    chk("model_residue", ref_crc(f64), 32'hDEBB20E3);
    send(f64, -1, 0, 0);
    chk("f64_ok", {31'h0, bus.res_ok}, 1);
    chk("f64_len", {16'h0, bus.res_len}, 64);
    chk("f64_cnt_good", {28'h0, cnt_good}, 1);
    fbad = f64;
    fbad[20] ^= 8'h20;
    idle_cycle();
    send(fbad, -1, 0, 0);
    chk("bad_crc_err", {31'h0, bus.res_crc_err}, 1);
    chk("bad_ok", {31'h0, bus.res_ok}, 0);
    chk("bad_cnt_bad", {28'h0, cnt_bad}, 1);
    f65 = build(61);
    send(f65, -1, 0, 0);
    chk("f65_ok", {31'h0, bus.res_ok}, 1);
    chk("f65_len", {16'h0, bus.res_len}, 65);
    send(f65, -1, 0, 1);
    chk("f65_garbage_ok", {31'h0, bus.res_ok}, 1);
    chk("f65_cnt_good", {28'h0, cnt_good}, 3);
    f20 = build(16);
    send(f20, -1, 0, 0);
    chk("f20_runt", {31'h0, bus.res_runt}, 1);
    chk("f20_crc_err", {31'h0, bus.res_crc_err}, 0);
    chk("f20_cnt_runt", {28'h0, cnt_runt}, 1);
    fone = '{8'h12, 8'h34};
    send(fone, -1, 0, 0);
    chk("one_len", {16'h0, bus.res_len}, 2);
    chk("one_runt", {31'h0, bus.res_runt}, 1);
    chk("one_crc_err", {31'h0, bus.res_crc_err}, 1);
    send(f64, 12, 0, 0);
    send(f64, -1, 0, 0);
    chk("abort_then_ok", {31'h0, bus.res_ok}, 1);
    chk("abort_cnt_bad", {28'h0, cnt_bad}, 3);
    chk("abort_cnt_runt", {28'h0, cnt_runt}, 3);
    send(f64, 12, 1, 0);
    send(f64, -1, 1, 1);
    chk("gaps_ok", {31'h0, bus.res_ok}, 1);
    chk("gaps_cnt_good", {28'h0, cnt_good}, 5);
    chk("gaps_cnt_bad", {28'h0, cnt_bad}, 4);
    fbig = build(69996);
    send(fbig, -1, 0, 0);
    chk("big_len_sat", {16'h0, bus.res_len}, 32'hFFFF);
    chk("big_ok", {31'h0, bus.res_ok}, 1);
    repeat (20) send(fbad, -1, 0, 0);
    chk("cnt_bad_sat", {28'h0, cnt_bad}, 15);
    repeat (3) idle_cycle();
    chk("cnt_bad_held", {28'h0, cnt_bad}, 15);
    send(f64, 10, 0, 0);
    open = 0;
    sys_rst_n = 0;
    repeat (2) idle_cycle();
    chk("rst_mid_cnt_good", {28'h0, cnt_good}, 0);
    chk("rst_mid_cnt_bad", {28'h0, cnt_bad}, 0);
    chk("rst_mid_res_valid", {31'h0, bus.res_valid}, 0);
    sys_rst_n = 1;
    repeat (2) idle_cycle();
    send(f64, -1, 0, 0);
    chk("post_rst_cnt_good", {28'h0, cnt_good}, 1);
    repeat (3) idle_cycle();
    chk("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
